// File: rtl/ysyx_22040729_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier, restoring divider, word (*W) ops in-block.
// Optional macro YSYX_22040729_MUL_SINGLE_CYCLE_EN swaps the iterative multiplier for a single-cycle array product.
module ysyx_22040729_mdu #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    input  logic [2:0]            func3,
    input  logic                  word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [1:0]            dbg_state
);
    localparam int W  = DATA_WIDTH;
    localparam int H  = DATA_WIDTH / 2;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid holds its payload until that edge, and ready never depends on the same-cycle valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            word_q;
    logic [2:0]      f3_q;
    logic            neg_q_q;   // negate product / quotient
    logic            neg_r_q;   // negate remainder (dividend sign)
    logic [2*W-1:0]  acc_q, mcand_q;
    logic [W-1:0]    mplier_q, quo_q, rem_q, dvs_q, result_q;

    function automatic logic [W-1:0] fmt(input logic [W-1:0] x, input logic w);
        return w ? {{H{x[H-1]}}, x[H-1:0]} : x;
    endfunction

    function automatic logic [W-1:0] mul_pick(input logic [2*W-1:0] mag, input logic neg,
                                              input logic [2:0] f3, input logic w);
        logic [2*W-1:0] p;
        p = neg ? -mag : mag;
        return fmt((f3[1:0] == 2'b00 || w) ? p[W-1:0] : p[2*W-1:W], w);
    endfunction

    // Request decode: sign handling and special divide cases on the active width
    logic          accept, in_is_div, s1_sgn, s2_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [W-1:0]  a_ext, b_ext, a_mag, b_mag, special_res;

    always_comb begin
        accept    = in_valid & in_ready & ~flush;
        in_is_div = func3[2];
        s1_sgn    = in_is_div ? ~func3[0] : (word | (func3[1:0] != 2'b11));
        s2_sgn    = in_is_div ? ~func3[0] : (word | ~func3[1]);
        a_ext     = word ? {{H{s1_sgn & src1[H-1]}}, src1[H-1:0]} : src1;
        b_ext     = word ? {{H{s2_sgn & src2[H-1]}}, src2[H-1:0]} : src2;
        a_neg     = s1_sgn & a_ext[W-1];
        b_neg     = s2_sgn & b_ext[W-1];
        a_mag     = a_neg ? -a_ext : a_ext;
        b_mag     = b_neg ? -b_ext : b_ext;
        div_zero  = (b_ext == '0);
        div_ovf   = ~func3[0] & (b_ext == '1) &
                    (word ? (a_ext[H-1:0] == {1'b1, {(H-1){1'b0}}})
                          : (a_ext == {1'b1, {(W-1){1'b0}}}));
        if (div_zero) special_res = fmt(func3[1] ? a_ext : '1, word);
        else          special_res = fmt(func3[1] ? '0 : a_ext, word);
    end

`ifdef YSYX_22040729_MUL_SINGLE_CYCLE_EN
    logic [2*W-1:0] mul_full;
    assign mul_full = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
`endif

    // One iteration step for each engine
    logic [2*W-1:0] acc_nx;
    logic [W:0]     r_sh;
    logic           r_ge, last;
    logic [W-1:0]   rem_nx, quo_nx, div_res;

    always_comb begin
        acc_nx  = acc_q + (mplier_q[0] ? mcand_q : '0);
        r_sh    = {rem_q, quo_q[W-1]};
        r_ge    = (r_sh >= {1'b0, dvs_q});
        rem_nx  = r_ge ? (r_sh[W-1:0] - dvs_q) : r_sh[W-1:0];
        quo_nx  = {quo_q[W-2:0], r_ge};
        last    = (cnt_q == (word_q ? CW'(H - 1) : CW'(W - 1)));
        div_res = fmt(f3_q[1] ? (neg_r_q ? -rem_nx : rem_nx)
                              : (neg_q_q ? -quo_nx : quo_nx), word_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) begin
                if (in_is_div)
                    state_d = (div_zero | div_ovf) ? S_DONE : S_DIV;
                else
`ifdef YSYX_22040729_MUL_SINGLE_CYCLE_EN
                    state_d = S_DONE;
`else
                    state_d = S_MUL;
`endif
            end
            S_MUL, S_DIV: if (last) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            word_q   <= 1'b0;
            f3_q     <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    cnt_q    <= '0;
                    word_q   <= word;
                    f3_q     <= func3;
                    neg_q_q  <= a_neg ^ b_neg;
                    neg_r_q  <= a_neg;
                    acc_q    <= '0;
                    mcand_q  <= {{W{1'b0}}, a_mag};
                    mplier_q <= b_mag;
                    // Word dividends are pre-shifted so their MSB enters the remainder first
                    quo_q    <= word ? (a_mag << H) : a_mag;
                    rem_q    <= '0;
                    dvs_q    <= b_mag;
                    if (in_is_div && (div_zero || div_ovf))
                        result_q <= special_res;
`ifdef YSYX_22040729_MUL_SINGLE_CYCLE_EN
                    if (!in_is_div)
                        result_q <= mul_pick(mul_full, a_neg ^ b_neg, func3, word);
`endif
                end
                S_MUL: begin
                    acc_q    <= acc_nx;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last) result_q <= mul_pick(acc_nx, neg_q_q, f3_q, word_q);
                end
                S_DIV: begin
                    quo_q <= quo_nx;
                    rem_q <= rem_nx;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) result_q <= div_res;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_22040729_mdu.sv
// Directed bench for ysyx_22040729_mdu (DATA_WIDTH=64); expected values are hand-computed.
module tb_ysyx_22040729_mdu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic [2:0]  func3 = '0;
  logic        word = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

`ifdef YSYX_22040729_MUL_SINGLE_CYCLE_EN
  localparam int MUL_LAT = 1;
  localparam int MULW_LAT = 1;
`else
  localparam int MUL_LAT = 65;
  localparam int MULW_LAT = 33;
`endif

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINUS7 = 64'hFFFF_FFFF_FFFF_FFF9;

  ysyx_22040729_mdu #(.DATA_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .func3(func3), .word(word),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  // driver: offer one request, wait for out_valid (bounded), then consume it
  task automatic run_op(input vec_t v, output int lat, output logic [63:0] res);
    @(negedge clk);
    func3 = v.f3; word = v.w; src1 = v.a; src2 = v.b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    res = 'x;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = k;
        res = result;
        break;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'd0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=%h state=%0d expected 1 0 0 0",
               in_ready, out_valid, result, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_divide();
    vec_t t[9];
    int lat;
    logic [63:0] res;
    t[0] = '{"div_by_zero_q", 3'b100, 1'b0, 64'd7, 64'd0, ONES, 1};
    t[1] = '{"div_by_zero_r", 3'b110, 1'b0, 64'd7, 64'd0, 64'd7, 1};
    t[2] = '{"ovf_q", 3'b100, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1};
    t[3] = '{"ovf_r", 3'b110, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, 1};
    t[4] = '{"div_neg", 3'b100, 1'b0, MINUS7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    t[5] = '{"rem_neg", 3'b110, 1'b0, MINUS7, 64'd2, ONES, 65};
    t[6] = '{"divu", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    t[7] = '{"remu", 3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    t[8] = '{"divu_big", 3'b101, 1'b0, ONES, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 65};
    for (int i = 0; i < 9; i++) begin
      run_op(t[i], lat, res);
      vectors++;
      if (res !== t[i].exp) begin
        miscompares++;
        $display("FAIL %s result: got %h expected %h", t[i].name, res, t[i].exp);
      end
      vectors++;
      if (lat != t[i].lat) begin
        miscompares++;
        $display("FAIL %s latency: got %0d expected %0d", t[i].name, lat, t[i].lat);
      end
    end
  endtask

  task automatic test_word();
    vec_t t[9];
    int lat;
    logic [63:0] res;
    t[0] = '{"divuw", 3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, 33};
    t[1] = '{"divw", 3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    t[2] = '{"remw", 3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, ONES, 33};
    t[3] = '{"remuw", 3'b111, 1'b1, 64'hFFFF_FFFF_0000_0009, 64'd4, 64'd1, 33};
    t[4] = '{"divw_zero", 3'b100, 1'b1, 64'd5, 64'h1_0000_0000, ONES, 1};
    t[5] = '{"remw_zero", 3'b110, 1'b1, 64'd5, 64'h1_0000_0000, 64'd5, 1};
    t[6] = '{"divw_ovf", 3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    t[7] = '{"mulw", 3'b000, 1'b1, 64'h1_0000_0002, 64'd3, 64'd6, MULW_LAT};
    t[8] = '{"mulhuw_as_mulw", 3'b011, 1'b1, 64'hFFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, MULW_LAT};
    for (int i = 0; i < 9; i++) begin
      run_op(t[i], lat, res);
      vectors++;
      if (res !== t[i].exp) begin
        miscompares++;
        $display("FAIL %s result: got %h expected %h", t[i].name, res, t[i].exp);
      end
      vectors++;
      if (lat != t[i].lat) begin
        miscompares++;
        $display("FAIL %s latency: got %0d expected %0d", t[i].name, lat, t[i].lat);
      end
    end
  endtask

  task automatic test_multiply();
    vec_t t[6];
    int lat;
    logic [63:0] res;
    t[0] = '{"mul_neg", 3'b000, 1'b0, 64'd6, MINUS7, 64'hFFFF_FFFF_FFFF_FFD6, MUL_LAT};
    t[1] = '{"mulh_m1", 3'b001, 1'b0, ONES, ONES, 64'd0, MUL_LAT};
    t[2] = '{"mulhu_max", 3'b011, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT};
    t[3] = '{"mulhsu", 3'b010, 1'b0, ONES, 64'd2, ONES, MUL_LAT};
    t[4] = '{"mulh_carry", 3'b001, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, MUL_LAT};
    t[5] = '{"mul_low", 3'b000, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT};
    for (int i = 0; i < 6; i++) begin
      run_op(t[i], lat, res);
      vectors++;
      if (res !== t[i].exp) begin
        miscompares++;
        $display("FAIL %s result: got %h expected %h", t[i].name, res, t[i].exp);
      end
      vectors++;
      if (lat != t[i].lat) begin
        miscompares++;
        $display("FAIL %s latency: got %0d expected %0d", t[i].name, lat, t[i].lat);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    func3 = 3'b100; word = 1'b0; src1 = 64'd7; src2 = 64'd0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== ONES) begin
        miscompares++;
        $display("FAIL backpressure cycle %0d: out_valid=%b in_ready=%b result=%h expected 1 0 %h",
                 k, out_valid, in_ready, result, ONES);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ir;
    @(negedge clk);
    func3 = 3'b100; word = 1'b0; src1 = 64'd9; src2 = 64'd0; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      exp_ir = (k % 2 == 0);
      vectors++;
      if (in_ready !== exp_ir || out_valid !== !exp_ir || (!exp_ir && result !== ONES)) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: in_ready=%b out_valid=%b result=%h expected %b %b %h",
                 k, in_ready, out_valid, result, exp_ir, !exp_ir, ONES);
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic seen;
    int lat;
    logic [63:0] res;
    vec_t v;
    @(negedge clk);
    func3 = 3'b100; word = 1'b0; src1 = 64'd100; src2 = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    // a special-case request offered during flush must be ignored
    flush = 1'b1; src2 = 64'd0; in_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL flush_to_idle: in_ready=%b out_valid=%b state=%0d expected 1 0 0",
               in_ready, out_valid, dbg_state);
    end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_result: out_valid seen=%b expected 0", seen);
    end
    v = '{"after_flush", 3'b100, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    run_op(v, lat, res);
    vectors++;
    if (res !== 64'd14 || lat != 65) begin
      miscompares++;
      $display("FAIL after_flush: result=%h latency=%0d expected %h 65", res, lat, 64'd14);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    logic [63:0] res;
    vec_t v;
    @(negedge clk);
    func3 = 3'b101; word = 1'b0; src1 = 64'd50; src2 = 64'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'd0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_mid_op: in_ready=%b out_valid=%b result=%h state=%0d expected 1 0 0 0",
               in_ready, out_valid, result, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = '{"after_reset", 3'b111, 1'b0, 64'd50, 64'd3, 64'd2, 65};
    run_op(v, lat, res);
    vectors++;
    if (res !== 64'd2 || lat != 65) begin
      miscompares++;
      $display("FAIL after_reset: result=%h latency=%0d expected %h 65", res, lat, 64'd2);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_word();
    test_multiply();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
